// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the uart_rx_fifo receiver.
// The PARITY state is only reached when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam int DATA_BITS = 8;

  // Counter preload that lands the start-bit sample in the middle of the bit.
  function automatic int half_bit_count(input int clks_per_bit);
    return (clks_per_bit / 2) - 1;
  endfunction

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; rdata_o reads 0 while empty.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             empty_s, full_s, do_push_s, do_pop_s;

  assign empty_s   = (count_q == {(AW + 1){1'b0}});
  assign full_s    = (count_q == CNT_FULL);
  assign do_pop_s  = pop_i & ~empty_s;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_push_s = push_i & (~full_s | pop_i);

  always_comb begin
    wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
  assign empty_o = empty_s;
  assign full_o  = full_s;
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a fall-through FIFO, with sticky error flags.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err_o output.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int  CLKS_PER_BIT = 347,
  parameter int  FIFO_DEPTH   = 8,
  localparam int FIFO_AW      = $clog2(FIFO_DEPTH)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               rx_i,
  input  logic               rd_en_i,
  input  logic               clear_err_i,
  output logic [7:0]         data_o,
  output logic               valid_o,
  output logic [FIFO_AW:0]   fifo_count_o,
  output logic               rx_busy_o,
  output logic               frame_err_o,
  output logic               overrun_o,
  output logic               irq_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic               parity_err_o
`endif
);

  localparam int              CNT_W       = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(half_bit_count(CLKS_PER_BIT));
  localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

  logic             sync1_q, sync2_q, rx_s;
  logic [1:0]       settle_q;
  logic             armed_q;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             frame_err_q, overrun_q;
  logic             tick_s, stop_tick_s, push_s, frame_set_s, ovr_set_s;
  logic             fifo_empty_s, fifo_full_s;
  logic             err_any_s;

  // settle_q marks when both synchronizer stages hold real line samples, so the
  // reset preset can never be mistaken for an idle level that arms reception.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= rx_i;
      sync2_q  <= sync1_q;
      settle_q <= {settle_q[0], 1'b1};
      armed_q  <= armed_q | (settle_q[1] & sync2_q);
    end
  end

  assign rx_s        = sync2_q;
  assign tick_s      = (cnt_q == CNT_ZERO);
  assign stop_tick_s = (state_q == STOP) && tick_s;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, parity_err_q, par_set_s;

  assign par_set_s = (state_q == PARITY) && tick_s && (rx_s != even_parity(shift_q));
  assign push_s    = stop_tick_s & rx_s & ~par_bad_q;
`else
  assign push_s    = stop_tick_s & rx_s;
`endif
  assign frame_set_s = stop_tick_s & ~rx_s;
  assign ovr_set_s   = push_s & fifo_full_s & ~rd_en_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q && !rx_s) begin
            state_q <= START;
            cnt_q   <= HALF_LOAD;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
          end
        end
        START: begin
          if (tick_s) begin
            if (rx_s) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              cnt_q     <= BIT_RELOAD;
              bit_idx_q <= 3'd0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        DATA: begin
          if (tick_s) begin
            shift_q <= {rx_s, shift_q[7:1]};
            cnt_q   <= BIT_RELOAD;
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_s) begin
            par_bad_q <= par_set_s;
            state_q   <= STOP;
            cnt_q     <= BIT_RELOAD;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (tick_s) begin
            state_q <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as clear_err_i takes priority.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= frame_set_s | (frame_err_q & ~clear_err_i);
      overrun_q    <= ovr_set_s   | (overrun_q   & ~clear_err_i);
`ifdef UART_RX_PARITY_EN
      parity_err_q <= par_set_s   | (parity_err_q & ~clear_err_i);
`endif
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push_s),
    .wdata_i (shift_q),
    .pop_i   (rd_en_i),
    .rdata_o (data_o),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s),
    .count_o (fifo_count_o)
  );

`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
  assign err_any_s    = frame_err_q | overrun_q | parity_err_q;
`else
  assign err_any_s    = frame_err_q | overrun_q;
`endif

  assign valid_o     = ~fifo_empty_s;
  assign rx_busy_o   = (state_q != IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign irq_o       = ~fifo_empty_s | err_any_s;

endmodule
